input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Multi-channel input front-end for slow asynchronous inputs such as buttons and switches.
- Per channel, in order: N-stage synchronizer, shared sample-tick prescaler, symmetric debounce, then rise/fall edge pulses and a long-press detector.
- Optional auto-repeat on each channel.
- Sits between the board pins and the CPU/MMIO in the top level. It generalises the current button path in channel count, synchronizer depth and event types.

Parameters:
- WIDTH, 4: number of independent channels.
- SYNC_STAGES, 2: synchronizer flops per channel; minimum 2.
- SAMPLE_CNT_MAX, 25000: clk cycles per sample tick.
- PULSE_CNT_MAX, 200: consecutive disagreeing ticks required to flip the debounced level.
- HOLD_CNT_MAX, 2000: ticks the level must stay high before a long pulse fires.
- REPEAT_CNT_MAX, 400: ticks between repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- in  in  WIDTH  raw asynchronous inputs.
- level  out  WIDTH  debounced level.
- rise  out  WIDTH  1-cycle pulse when level goes 0->1.
- fall  out  WIDTH  1-cycle pulse when level goes 1->0.
- long_press  out  WIDTH  1-cycle pulse once per press after hold.
- repeat  out  WIDTH  1-cycle auto-repeat pulse.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0. All synchronizer flops, counters and hold/repeat state are 0.
- Reset mid-operation: clears everything on the next edge, and no pulses are emitted. An input held high must re-debounce and then produces a fresh rise.
- Cycle numbering: cycle 0 is the first cycle with rst low.
- Synchronizer: in passes through SYNC_STAGES flops. Call the result s. A change on in is visible on s SYNC_STAGES cycles later.
- Prescaler: one shared counter, width $clog2(SAMPLE_CNT_MAX).
  - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - tick = (count == SAMPLE_CNT_MAX-1), high 1 cycle.
  - First tick occurs in cycle SAMPLE_CNT_MAX-1.
- Debounce, per channel: counter dcnt of width $clog2(PULSE_CNT_MAX+1).
  - On tick with s != level: dcnt+1. When dcnt+1 reaches PULSE_CNT_MAX, level toggles and dcnt clears.
  - On tick with s == level: dcnt clears.
  - No tick: dcnt holds.
  - Release is debounced exactly like press.
- Edges: rise and fall are registered and computed from the level next-state. They are high in the first cycle the new level is visible. rise and fall are never both high on the same channel.
- Hold FSM, per channel. States IDLE, HOLDING, LONG.
  - IDLE -> HOLDING on rise. hcnt := 0.
  - HOLDING: hcnt+1 each tick. When it reaches HOLD_CNT_MAX: long_press pulses 1 cycle and state -> LONG.
  - Any state -> IDLE on fall. hcnt clears.
  - If fall and the long terminal tick coincide, fall wins and no long_press fires.
  - At most one long_press per press.
- Channel independence: channels are fully independent except for the shared tick. Simultaneous events on different channels all fire in the same cycle.
- Counter width: all counters saturate or clear as stated and never wrap silently.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - In LONG, rcnt counts ticks. repeat pulses 1 cycle each time rcnt reaches REPEAT_CNT_MAX, then rcnt clears.
  - First repeat comes REPEAT_CNT_MAX ticks after long_press.
  - fall clears rcnt and suppresses any coincident repeat.
- Undefined: repeat is tied to 0, and no rcnt logic is synthesised.

Test Plan:
- Bench parameters for all scenarios: WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, HOLD_CNT_MAX=10, REPEAT_CNT_MAX=2.
- Clean press: in[0]=1 from cycle 0 -> ticks at 3, 7, 11; level[0] and rise[0] go high in cycle 12; rise[0] is low again in cycle 13; in[1] channel stays 0.
- Bounce: in[0] high for 5 cycles, then low -> no rise, level[0] stays 0; then a held low-to-high-low glitch on release of a debounced press -> single fall only.
- Long press: hold in[0] -> long_press[0] exactly once, 10 ticks (40 cycles) after rise; release -> fall, no further long_press; release landing on the terminal tick -> fall only.
- Auto-repeat (macro defined): keep holding after long_press -> repeat[0] every 8 cycles until fall; macro undefined -> repeat stays 0 throughout.
- Reset mid-press: rst for 1 cycle while level[0]=1 -> all outputs 0 next cycle, no fall pulse; with in[0] still high, rise[0] fires again in cycle 12 after release of reset.
- Simultaneous channels: in[1:0]=2'b11 in the same cycle -> rise=2'b11 in the same cycle, and later long_press=2'b11 in the same cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchronizer, shared sample-tick prescaler, symmetric debounce,
// rise/fall/long-press events. Auto-repeat is built only when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_conditioner #(
   parameter int WIDTH          = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int SAMPLE_CNT_MAX = 25000,
   parameter int PULSE_CNT_MAX  = 200,
   parameter int HOLD_CNT_MAX   = 2000,
   parameter int REPEAT_CNT_MAX = 400
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] long_press,
   output logic [WIDTH-1:0] repeat_pulse
);

   localparam int PS_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int DC_W = $clog2(PULSE_CNT_MAX + 1);
   localparam int HC_W = $clog2(HOLD_CNT_MAX + 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(SAMPLE_CNT_MAX - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(PULSE_CNT_MAX);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CNT_MAX);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam int RC_W = $clog2(REPEAT_CNT_MAX + 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REPEAT_CNT_MAX);
`endif

   if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
       HOLD_CNT_MAX < 1 || REPEAT_CNT_MAX < 1) begin : g_param_error
      $error("input_conditioner: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLDING = 2'd1,
      ST_LONG    = 2'd2
   } hold_state_t;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   logic [WIDTH-1:0]                  s_s;
   logic [PS_W-1:0]                   presc_r;
   logic                              tick_s;

   // Synchronizer chain: stage 0 captures the raw pins, the last stage feeds the debouncers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in};
      end
   end

   assign s_s    = sync_r[SYNC_STAGES-1];
   assign tick_s = (presc_r == PS_LAST);

   // Shared prescaler, wraps on the tick cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= {PS_W{1'b0}};
      end else if (tick_s) begin
         presc_r <= {PS_W{1'b0}};
      end else begin
         presc_r <= presc_r + PS_W'(1);
      end
   end

   for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
      logic            lvl_r, lvl_nx_s;
      logic [DC_W-1:0] dcnt_r, dcnt_nx_s;
      hold_state_t     state_r, state_nx_s;
      logic [HC_W-1:0] hcnt_r, hcnt_nx_s;
      logic            rise_r, fall_r, long_r, long_nx_s;
      logic            rise_ev_s, fall_ev_s;

      // Debounce: PULSE_CNT_MAX consecutive disagreeing ticks flip the level.
      always_comb begin
         lvl_nx_s  = lvl_r;
         dcnt_nx_s = dcnt_r;
         if (tick_s) begin
            if (s_s[ch] != lvl_r) begin
               if ((dcnt_r + DC_W'(1)) == DC_LAST) begin
                  lvl_nx_s  = ~lvl_r;
                  dcnt_nx_s = {DC_W{1'b0}};
               end else begin
                  dcnt_nx_s = dcnt_r + DC_W'(1);
               end
            end else begin
               dcnt_nx_s = {DC_W{1'b0}};
            end
         end else begin
            dcnt_nx_s = dcnt_r;
         end
      end

      assign rise_ev_s = lvl_nx_s & ~lvl_r;
      assign fall_ev_s = ~lvl_nx_s & lvl_r;

      // Hold FSM; a fall always wins over a coincident long-press terminal tick.
      always_comb begin
         state_nx_s = state_r;
         hcnt_nx_s  = hcnt_r;
         long_nx_s  = 1'b0;
         if (fall_ev_s) begin
            state_nx_s = ST_IDLE;
            hcnt_nx_s  = {HC_W{1'b0}};
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (rise_ev_s) begin
                     state_nx_s = ST_HOLDING;
                     hcnt_nx_s  = {HC_W{1'b0}};
                  end else begin
                     state_nx_s = ST_IDLE;
                  end
               end
               ST_HOLDING: begin
                  if (tick_s) begin
                     if ((hcnt_r + HC_W'(1)) == HC_LAST) begin
                        long_nx_s  = 1'b1;
                        state_nx_s = ST_LONG;
                        hcnt_nx_s  = {HC_W{1'b0}};
                     end else begin
                        hcnt_nx_s = hcnt_r + HC_W'(1);
                     end
                  end else begin
                     hcnt_nx_s = hcnt_r;
                  end
               end
               ST_LONG: begin
                  state_nx_s = ST_LONG;
               end
               default: begin
                  state_nx_s = ST_IDLE;
                  hcnt_nx_s  = {HC_W{1'b0}};
               end
            endcase
         end
      end

      // Per-channel state and registered event outputs.
      always_ff @(posedge clk) begin
         if (rst) begin
            lvl_r   <= 1'b0;
            dcnt_r  <= {DC_W{1'b0}};
            state_r <= ST_IDLE;
            hcnt_r  <= {HC_W{1'b0}};
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            long_r  <= 1'b0;
         end else begin
            lvl_r   <= lvl_nx_s;
            dcnt_r  <= dcnt_nx_s;
            state_r <= state_nx_s;
            hcnt_r  <= hcnt_nx_s;
            rise_r  <= rise_ev_s;
            fall_r  <= fall_ev_s;
            long_r  <= long_nx_s;
         end
      end

      assign level[ch]      = lvl_r;
      assign rise[ch]       = rise_r;
      assign fall[ch]       = fall_r;
      assign long_press[ch] = long_r;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      logic [RC_W-1:0] rcnt_r, rcnt_nx_s;
      logic            rpt_r, rpt_nx_s;

      // Repeat counter runs only in LONG; a fall clears it and masks a coincident repeat.
      always_comb begin
         rcnt_nx_s = rcnt_r;
         rpt_nx_s  = 1'b0;
         if (fall_ev_s || (state_r != ST_LONG)) begin
            rcnt_nx_s = {RC_W{1'b0}};
         end else if (tick_s) begin
            if ((rcnt_r + RC_W'(1)) == RC_LAST) begin
               rpt_nx_s  = 1'b1;
               rcnt_nx_s = {RC_W{1'b0}};
            end else begin
               rcnt_nx_s = rcnt_r + RC_W'(1);
            end
         end else begin
            rcnt_nx_s = rcnt_r;
         end
      end

      // Repeat state registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            rcnt_r <= {RC_W{1'b0}};
            rpt_r  <= 1'b0;
         end else begin
            rcnt_r <= rcnt_nx_s;
            rpt_r  <= rpt_nx_s;
         end
      end

      assign repeat_pulse[ch] = rpt_r;
`else
      assign repeat_pulse[ch] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with small timing parameters.
// Repeat expectations follow INPUT_CONDITIONER_AUTO_REPEAT_EN.
module tb_input_conditioner;

   logic       clk;
   logic       rst;
   logic [1:0] in;
   logic [1:0] level, rise, fall, long_press, repeat_pulse;

   int n_checks;
   int n_errors;
   int cyc;
   int rise_tot [2];
   int fall_tot [2];
   int long_tot [2];
   int rpt_tot  [2];
   int rise_base[2];
   int fall_base[2];
   int long_base[2];
   int rpt_base [2];

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam int RPT_EN = 1;
`else
   localparam int RPT_EN = 0;
`endif

   input_conditioner #(
      .WIDTH          (2),
      .SYNC_STAGES    (2),
      .SAMPLE_CNT_MAX (4),
      .PULSE_CNT_MAX  (3),
      .HOLD_CNT_MAX   (10),
      .REPEAT_CNT_MAX (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in           (in),
      .level        (level),
      .rise         (rise),
      .fall         (fall),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event totals per channel, sampled on the inactive edge.
   initial begin
      for (int i = 0; i < 2; i++) begin
         rise_tot[i] = 0;
         fall_tot[i] = 0;
         long_tot[i] = 0;
         rpt_tot[i]  = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rise[i] === 1'b1)         rise_tot[i] = rise_tot[i] + 1;
         if (fall[i] === 1'b1)         fall_tot[i] = fall_tot[i] + 1;
         if (long_press[i] === 1'b1)   long_tot[i] = long_tot[i] + 1;
         if (repeat_pulse[i] === 1'b1) rpt_tot[i]  = rpt_tot[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) step();
   endtask

   // One reset edge; returns at the start of cycle 0 with rst low.
   task automatic do_reset(input logic [1:0] in_val);
      rst = 1'b1;
      in  = in_val;
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         rise_base[i] = rise_tot[i];
         fall_base[i] = fall_tot[i];
         long_base[i] = long_tot[i];
         rpt_base[i]  = rpt_tot[i];
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      rst      = 1'b1;
      in       = 2'b00;
      step();
      step();

      // Reset state and clean press, long press, repeat, release
      do_reset(2'b00);
      snap();
      chk("reset_level", level, 2'b00);
      chk("reset_rise", rise, 2'b00);
      chk("reset_fall", fall, 2'b00);
      chk("reset_long", long_press, 2'b00);
      chk("reset_repeat", repeat_pulse, 2'b00);
      in = 2'b01;
      goto(11);
      chk("press_level_c11", level, 2'b00);
      chk("press_rise_c11", rise, 2'b00);
      goto(12);
      chk("press_level_c12", level, 2'b01);
      chk("press_rise_c12", rise, 2'b01);
      chk("press_fall_c12", fall, 2'b00);
      goto(13);
      chk("press_rise_c13", rise, 2'b00);
      chk("press_level_c13", level, 2'b01);
      goto(51);
      chk("long_c51", long_press, 2'b00);
      goto(52);
      chk("long_c52", long_press, 2'b01);
      goto(53);
      chk("long_c53", long_press, 2'b00);
      goto(59);
      chk("repeat_c59", repeat_pulse, 2'b00);
      goto(60);
      chk("repeat_c60", repeat_pulse, (RPT_EN == 1) ? 2'b01 : 2'b00);
      goto(61);
      chk("repeat_c61", repeat_pulse, 2'b00);
      goto(68);
      chk("repeat_c68", repeat_pulse, (RPT_EN == 1) ? 2'b01 : 2'b00);
      goto(70);
      in = 2'b00;
      goto(83);
      chk("release_level_c83", level, 2'b01);
      chk("release_fall_c83", fall, 2'b00);
      goto(84);
      chk("release_level_c84", level, 2'b00);
      chk("release_fall_c84", fall, 2'b01);
      chk("release_repeat_c84", repeat_pulse, 2'b00);
      goto(85);
      chk("release_fall_c85", fall, 2'b00);
      goto(90);
      chk("s1_rise_cnt0", rise_tot[0] - rise_base[0], 1);
      chk("s1_fall_cnt0", fall_tot[0] - fall_base[0], 1);
      chk("s1_long_cnt0", long_tot[0] - long_base[0], 1);
      chk("s1_repeat_cnt0", rpt_tot[0] - rpt_base[0], (RPT_EN == 1) ? 3 : 0);
      chk("s1_rise_cnt1", rise_tot[1] - rise_base[1], 0);
      chk("s1_long_cnt1", long_tot[1] - long_base[1], 0);

      // Bounce on press, then a glitch during release
      snap();
      do_reset(2'b00);
      in = 2'b01;
      goto(5);
      in = 2'b00;
      goto(20);
      chk("bounce_level_c20", level, 2'b00);
      chk("bounce_rise_cnt", rise_tot[0] - rise_base[0], 0);
      in = 2'b01;
      goto(31);
      chk("glitch_level_c31", level, 2'b00);
      goto(32);
      chk("glitch_level_c32", level, 2'b01);
      chk("glitch_rise_c32", rise, 2'b01);
      goto(40);
      in = 2'b00;
      goto(44);
      in = 2'b01;
      goto(47);
      in = 2'b00;
      goto(48);
      chk("glitch_level_c48", level, 2'b01);
      goto(59);
      chk("glitch_level_c59", level, 2'b01);
      chk("glitch_fall_c59", fall, 2'b00);
      goto(60);
      chk("glitch_level_c60", level, 2'b00);
      chk("glitch_fall_c60", fall, 2'b01);
      goto(61);
      chk("glitch_fall_c61", fall, 2'b00);
      goto(66);
      chk("s2_rise_cnt", rise_tot[0] - rise_base[0], 1);
      chk("s2_fall_cnt", fall_tot[0] - fall_base[0], 1);
      chk("s2_long_cnt", long_tot[0] - long_base[0], 0);

      // Release landing on the long-press terminal tick
      snap();
      do_reset(2'b00);
      in = 2'b01;
      goto(12);
      chk("term_rise_c12", rise, 2'b01);
      goto(41);
      in = 2'b00;
      goto(51);
      chk("term_level_c51", level, 2'b01);
      goto(52);
      chk("term_level_c52", level, 2'b00);
      chk("term_fall_c52", fall, 2'b01);
      chk("term_long_c52", long_press, 2'b00);
      goto(60);
      chk("s3_long_cnt", long_tot[0] - long_base[0], 0);
      chk("s3_fall_cnt", fall_tot[0] - fall_base[0], 1);
      chk("s3_repeat_cnt", rpt_tot[0] - rpt_base[0], 0);

      // Reset while pressed
      snap();
      do_reset(2'b00);
      in = 2'b01;
      goto(12);
      chk("rstmid_level_c12", level, 2'b01);
      goto(20);
      do_reset(2'b01);
      chk("rstmid_level", level, 2'b00);
      chk("rstmid_rise", rise, 2'b00);
      chk("rstmid_fall", fall, 2'b00);
      chk("rstmid_long", long_press, 2'b00);
      goto(11);
      chk("rstmid_level_c11", level, 2'b00);
      chk("rstmid_rise_c11", rise, 2'b00);
      goto(12);
      chk("rstmid_rise_c12", rise, 2'b01);
      chk("rstmid_level_c12b", level, 2'b01);
      goto(14);
      chk("s4_fall_cnt", fall_tot[0] - fall_base[0], 0);
      chk("s4_rise_cnt", rise_tot[0] - rise_base[0], 2);

      // Both channels together
      snap();
      do_reset(2'b00);
      in = 2'b11;
      goto(11);
      chk("both_rise_c11", rise, 2'b00);
      goto(12);
      chk("both_rise_c12", rise, 2'b11);
      chk("both_level_c12", level, 2'b11);
      goto(51);
      chk("both_long_c51", long_press, 2'b00);
      goto(52);
      chk("both_long_c52", long_press, 2'b11);
      goto(53);
      in = 2'b00;
      goto(60);
      chk("both_repeat_c60", repeat_pulse, (RPT_EN == 1) ? 2'b11 : 2'b00);
      goto(63);
      chk("both_fall_c63", fall, 2'b00);
      goto(64);
      chk("both_fall_c64", fall, 2'b11);
      chk("both_level_c64", level, 2'b00);
      chk("both_repeat_c64", repeat_pulse, 2'b00);
      goto(68);
      chk("s5_long_cnt1", long_tot[1] - long_base[1], 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
